// File: rtl/egg_timer_datapath.sv
// Egg-timer countdown datapath: preset load, 1 Hz BCD countdown, expiry flag and display blink.
// Optional macro TIMER_PAUSE_EN adds a pause input that freezes the countdown while in TIMER.
module egg_timer_datapath #(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [7:0] sw,
`ifdef TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank,
  output logic       expired
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [3:0] ST_SET_SEC     = 4'd0;
  localparam logic [3:0] ST_SET_MIN     = 4'd1;
  localparam logic [3:0] ST_TIMER       = 4'd2;
  localparam logic [3:0] ST_READY       = 4'd3;
  localparam logic [3:0] ST_FLASH_ON    = 4'd5;
  localparam logic [3:0] ST_FLASH_OFF   = 4'd6;
  localparam logic [3:0] ST_SETTING_MIN = 4'd7;

  logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          blank_q, blank_d;
  logic          expired_q, expired_d;
  logic          pause_s;
  logic          zero_s;

  function automatic logic [7:0] clamp_sec(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, o};
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    o = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, o};
  endfunction

`ifdef TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign zero_s = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                  (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  // Next-state decode: the controller state alone selects the action each cycle.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    presc_d    = presc_q;
    blink_d    = {BW{1'b0}};
    blank_d    = 1'b0;
    expired_d  = expired_q;
    case (state)
      ST_SET_SEC:     {sec_tens_d, sec_ones_d} = clamp_sec(sw);
      ST_SET_MIN:     {min_tens_d, min_ones_d} = clamp_min(sw);
      ST_SETTING_MIN: begin
      end
      ST_READY:       presc_d = {PW{1'b0}};
      ST_TIMER: begin
        if (pause_s) begin
          presc_d = presc_q;
        end else if (presc_q != PRESC_LAST) begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
          presc_d = {PW{1'b0}};
          if (zero_s) begin
            expired_d = 1'b1;
          end else if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
          end else begin
            // Borrow ripples upward; a nonzero value guarantees it stops before underflow.
            sec_ones_d = 4'd9;
            if (sec_tens_q != 4'd0) begin
              sec_tens_d = sec_tens_q - 4'd1;
            end else begin
              sec_tens_d = 4'd5;
              if (min_ones_q != 4'd0) begin
                min_ones_d = min_ones_q - 4'd1;
              end else begin
                min_ones_d = 4'd9;
                min_tens_d = min_tens_q - 4'd1;
              end
            end
          end
        end
      end
      ST_FLASH_ON: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = {BW{1'b0}};
          blank_d = ~blank_q;
        end else begin
          blink_d = blink_q + {{(BW-1){1'b0}}, 1'b1};
          blank_d = blank_q;
        end
      end
      ST_FLASH_OFF:   blank_d = 1'b1;
      default: begin
        min_tens_d = 4'd0;
        min_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        sec_ones_d = 4'd0;
        presc_d    = {PW{1'b0}};
        expired_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      presc_q    <= {PW{1'b0}};
      blink_q    <= {BW{1'b0}};
      blank_q    <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      blank_q    <= blank_d;
      expired_q  <= expired_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign blank    = blank_q;
  assign expired  = expired_q;

endmodule

// File: doc/egg_timer_datapath.md
Name: egg_timer_datapath

Overview:
Countdown datapath that sits directly downstream of the egg-timer controller FSM and consumes its 4-bit state code. It loads the MM:SS preset from the board switches, counts down at 1 Hz while the timer runs, and drives BCD digits, a display-blank strobe and an expiry flag to the 7-segment/LED output stage. It contains no decision logic of its own: every mode change is dictated by the state input.

Parameters:
CLK_HZ, 50000000, clk cycles per 1 s countdown tick; must be >= 2.
BLINK_DIV, 12500000, clk cycles per blank-toggle half-period in FLASH_ON; must be >= 1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
state  input  4  controller state code: 0 SET_SEC, 1 SET_MIN, 2 TIMER, 3 READY, 4 RESET, 5 FLASH_ON, 6 FLASH_OFF, 7 SETTING_MIN, 8-15 illegal
sw  input  8  preset digits: sw[7:4] tens, sw[3:0] ones, BCD
min_tens  output  4  minutes tens digit, BCD
min_ones  output  4  minutes ones digit, BCD
sec_tens  output  4  seconds tens digit, BCD
sec_ones  output  4  seconds ones digit, BCD
blank  output  1  1 = display must be dark
expired  output  1  countdown reached 00:00 while in TIMER

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high. All outputs are registered.
- On rst assertion: all digits 0, blank 0, expired 0, prescaler 0, blink counter 0.
- Clamp rule for loads: tens digit > 5 loads 5 for seconds; tens digit > 9 loads 9 for minutes; ones digit > 9 loads 9.
- Per-state actions, evaluated every clk:
  - RESET, or any illegal code 8-15: synchronously clear all digits, prescaler, blink counter, blank and expired.
  - SET_SEC: sec <= clamp(sw), with 1-cycle latency sw -> outputs. Minutes hold.
  - SETTING_MIN: hold all digits. sw still shows the seconds value while the key is held, so nothing is loaded.
  - SET_MIN: min <= clamp(sw), 1-cycle latency. Seconds hold.
  - READY: hold digits; prescaler forced to 0. The first tick therefore occurs exactly CLK_HZ cycles after entering TIMER.
  - TIMER: prescaler counts 0..CLK_HZ-1. The cycle where prescaler == CLK_HZ-1 is the tick, and the prescaler wraps to 0.
  - TIMER tick, value != 00:00: BCD decrement with borrow chain. sec_ones 0 goes to 9 and borrows; sec_tens 0 goes to 5 and borrows; min_ones 0 goes to 9 and borrows; min_tens decrements.
  - TIMER tick, value already 00:00: digits hold at 0 and expired is set.
  - TIMER, expired: the transition 00:01 -> 00:00 does not itself set expired; the next tick does. Entering TIMER with 00:00 sets expired on the first tick.
  - FLASH_ON: digits hold. The blink counter runs and blank toggles every BLINK_DIV cycles. blank is 0 on the first cycle in FLASH_ON.
  - FLASH_OFF: blank = 1, blink counter held at 0, digits hold.
- blank is 0 in every state other than FLASH_ON and FLASH_OFF.
- Leaving FLASH_ON/FLASH_OFF clears the blink counter.
- expired is sticky and is cleared only by rst or by state RESET / illegal codes.
- Leaving TIMER mid-second freezes the prescaler value. It is re-zeroed only by READY, RESET or rst.
- rst asserted mid-count immediately forces all outputs to their reset values, with no wait for clk.

Optional Feature:
TIMER_PAUSE_EN.
- Defined: adds input port pause (1 bit, after sw). While pause = 1 in TIMER, the prescaler and digits freeze. When pause returns to 0, counting resumes from the frozen prescaler value. pause has no effect in any other state.
- Undefined: no pause port, and countdown is unconditional in TIMER.

Test Plan:
1. CLK_HZ=10. rst pulse, then state=0 with sw=8'h45, then state=7 with sw=8'h12, then state=1 with sw=8'h03 -> after 1 cycle sec=45. In state 7 sec=45 and min=00 (no load). In state 1 min=03; final display 03:45.
2. Preset 01:00, state=3 for 5 cycles, then state=2 -> first decrement to 00:59 exactly 10 cycles after entering TIMER. Further ticks give 00:58, 00:57 at 10-cycle spacing.
3. Preset 00:01, state=2 -> 00:00 at cycle 10 with expired=0; expired=1 at cycle 20 and stays 1. Then state=4 -> digits 0, expired 0 next cycle.
4. sw=8'hAF in SET_SEC -> sec=59. sw=8'hF7 in SET_MIN -> min=97. state=9 -> all outputs cleared next cycle.
5. BLINK_DIV=4, state=5 -> blank sequence 0,0,0,0,1,1,1,1,0,... Then state=6 -> blank=1 steady. Then state=3 -> blank=0.
6. TIMER mid-second, assert rst asynchronously between clk edges -> digits, blank and expired go to 0 immediately. With TIMER_PAUSE_EN defined, pause=1 for 7 cycles delays the next tick by exactly 7 cycles.
